ram_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port, negedge-clocked 4096×32 data RAM. It multiplexes a primary requester (port A, the processor memory stage) and a secondary requester (port B, e.g. a DMA or display fetch engine) onto the RAM's single wEn/addr/dataIn/dataOut port. Arbitration is round-robin with bounded bursts. Each accepted read returns its data one cycle later, tagged with a per-port valid pulse.

---
 rtl/ram_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin, burst-bounded arbiter that shares one negedge-clocked data RAM
// port between a primary (A) and a secondary (B) requester.
module ram_port_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int MAX_BURST     = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     a_req,
  input  logic                     a_wen,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]    a_wdata,
  output logic                     a_gnt,
  output logic [DATA_WIDTH-1:0]    a_rdata,
  output logic                     a_rvalid,
  input  logic                     b_req,
  input  logic                     b_wen,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]    b_wdata,
  output logic                     b_gnt,
  output logic [DATA_WIDTH-1:0]    b_rdata,
  output logic                     b_rvalid,
  output logic                     ram_wen,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  input  logic [DATA_WIDTH-1:0]    ram_dout
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE_A  = 2'd0,
    IDLE_B  = 2'd1,
    BURST_A = 2'd2,
    BURST_B = 2'd3
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               pend_r;
  logic               pend_b_r;

  logic                     a_gnt_s;
  logic                     b_gnt_s;
  logic                     xfer_s;
  logic                     sel_wen_s;
  logic [ADDRESS_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0]    sel_wdata_s;

  // Grant decision: the idle state remembers whose turn it is; a burst owner
  // keeps the port until it saturates while the other side is waiting.
  always_comb begin
    a_gnt_s = 1'b0;
    b_gnt_s = 1'b0;
    case (state_r)
      IDLE_A: begin
        if (a_req) begin
          a_gnt_s = 1'b1;
        end else begin
          b_gnt_s = b_req;
        end
      end
      IDLE_B: begin
        if (b_req) begin
          b_gnt_s = 1'b1;
        end else begin
          a_gnt_s = a_req;
        end
      end
      BURST_A: begin
        if (a_req && ((cnt_r < CNT_MAX) || !b_req)) begin
          a_gnt_s = 1'b1;
        end else begin
          b_gnt_s = b_req;
        end
      end
      BURST_B: begin
        if (b_req && ((cnt_r < CNT_MAX) || !a_req)) begin
          b_gnt_s = 1'b1;
        end else begin
          a_gnt_s = a_req;
        end
      end
      default: begin
        a_gnt_s = 1'b0;
        b_gnt_s = 1'b0;
      end
    endcase
  end

  assign a_gnt       = a_gnt_s & reset_n;
  assign b_gnt       = b_gnt_s & reset_n;
  assign xfer_s      = a_gnt_s | b_gnt_s;
  assign sel_wen_s   = b_gnt_s ? b_wen   : a_wen;
  assign sel_addr_s  = b_gnt_s ? b_addr  : a_addr;
  assign sel_wdata_s = b_gnt_s ? b_wdata : a_wdata;

  // Arbitration state and saturating burst counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE_A;
      cnt_r   <= CNT_ZERO;
    end else if (a_gnt_s) begin
      state_r <= BURST_A;
      if (state_r == BURST_A) begin
        cnt_r <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
      end else begin
        cnt_r <= CNT_ONE;
      end
    end else if (b_gnt_s) begin
      state_r <= BURST_B;
      if (state_r == BURST_B) begin
        cnt_r <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
      end else begin
        cnt_r <= CNT_ONE;
      end
    end else begin
      cnt_r <= CNT_ZERO;
      case (state_r)
        BURST_A: state_r <= IDLE_B;
        BURST_B: state_r <= IDLE_A;
        default: state_r <= state_r;
      endcase
    end
  end

  // RAM command register; the RAM samples it on the following falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_wen  <= 1'b0;
      ram_addr <= {ADDRESS_WIDTH{1'b0}};
      ram_din  <= {DATA_WIDTH{1'b0}};
      pend_r   <= 1'b0;
      pend_b_r <= 1'b0;
    end else if (xfer_s) begin
      ram_wen  <= sel_wen_s;
      ram_addr <= sel_addr_s;
      ram_din  <= sel_wen_s ? sel_wdata_s : ram_din;
      pend_r   <= ~sel_wen_s;
      pend_b_r <= b_gnt_s;
    end else begin
      ram_wen  <= 1'b0;
      ram_addr <= ram_addr;
      ram_din  <= ram_din;
      pend_r   <= 1'b0;
      pend_b_r <= pend_b_r;
    end
  end

  // Read return: route RAM output to the port that issued the pending read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rdata  <= {DATA_WIDTH{1'b0}};
      b_rdata  <= {DATA_WIDTH{1'b0}};
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
    end else begin
      a_rvalid <= pend_r & ~pend_b_r;
      b_rvalid <= pend_r &  pend_b_r;
      a_rdata  <= (pend_r && !pend_b_r) ? ram_dout : a_rdata;
      b_rdata  <= (pend_r &&  pend_b_r) ? ram_dout : b_rdata;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter with a negedge RAM model and a
// request-level reference model of arbitration and read return.
module tb_ram_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          a_req, a_wen, b_req, b_wen;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_wen(a_wen), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_wen(b_wen), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port RAM: acts on the falling edge, writes leave dataOut alone.
  logic [DW-1:0] ram_mem [0:4095];
  always @(negedge clk) begin
    if (ram_wen) ram_mem[ram_addr] <= ram_din;
    else         ram_dout <= ram_mem[ram_addr];
  end

  // Reference model state
  logic [DW-1:0] shadow [0:4095];
  int            streak, holder, favored, pend_port;
  logic [DW-1:0] pend_data, exp_a_rdata, exp_b_rdata, last_din;
  logic [AW-1:0] last_addr;
  int            errors = 0;
  int            checks = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    streak = 0; holder = 0; favored = 0; pend_port = -1;
    pend_data = '0; exp_a_rdata = '0; exp_b_rdata = '0;
    last_addr = '0; last_din = '0;
  endtask

  // One clock cycle: apply inputs, check grants, advance, check RAM port and read return.
  task automatic step(input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      output int gobs);
    int            g, other, new_pend;
    logic          rq [2];
    logic          exp_wen, isw;
    logic [AW-1:0] exp_addr, waddr;
    logic [DW-1:0] exp_din, new_data, wd;
    a_req = ar; a_wen = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_wen = bw; b_addr = ba; b_wdata = bd;
    #1;
    rq[0] = ar; rq[1] = br;
    g = -1;
    if (streak > 0) begin
      other = 1 - holder;
      if (rq[holder] && (streak < MB || !rq[other])) g = holder;
      else if (rq[other]) g = other;
    end else begin
      other = 1 - favored;
      if (rq[favored]) g = favored;
      else if (rq[other]) g = other;
    end
    gobs = a_gnt ? 0 : (b_gnt ? 1 : -1);
    check_val("a_gnt", {31'd0, a_gnt}, {31'd0, g == 0});
    check_val("b_gnt", {31'd0, b_gnt}, {31'd0, g == 1});

    new_pend = -1; new_data = '0; exp_wen = 1'b0;
    exp_addr = last_addr; exp_din = last_din;
    if (g >= 0) begin
      waddr = (g == 0) ? aa : ba;
      isw   = (g == 0) ? aw : bw;
      wd    = (g == 0) ? ad : bd;
      exp_addr = waddr;
      if (isw) begin
        shadow[waddr] = wd; exp_wen = 1'b1; exp_din = wd;
      end else begin
        new_pend = g; new_data = shadow[waddr];
      end
    end
    if (g >= 0 && streak > 0 && g == holder) streak = (streak < MB) ? streak + 1 : MB;
    else if (g >= 0) begin holder = g; streak = 1; end
    else begin
      if (streak > 0) favored = 1 - holder;
      streak = 0;
    end

    @(posedge clk); #1;
    check_val("ram_wen", {31'd0, ram_wen}, {31'd0, exp_wen});
    check_val("ram_addr", {20'd0, ram_addr}, {20'd0, exp_addr});
    check_val("ram_din", ram_din, exp_din);
    last_addr = exp_addr; last_din = exp_din;
    if (pend_port == 0) exp_a_rdata = pend_data;
    if (pend_port == 1) exp_b_rdata = pend_data;
    check_val("a_rvalid", {31'd0, a_rvalid}, {31'd0, pend_port == 0});
    check_val("b_rvalid", {31'd0, b_rvalid}, {31'd0, pend_port == 1});
    check_val("a_rdata", a_rdata, exp_a_rdata);
    check_val("b_rdata", b_rdata, exp_b_rdata);
    pend_port = new_pend; pend_data = new_data;
  endtask

  // Short reset pulse that fits between two rising edges.
  task automatic pulse_reset();
    a_req = 1'b0; b_req = 1'b0;
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int            g;
    int            ai, bi;
    logic          ra, rw_a, rb, rw_b;
    logic [AW-1:0] raa, rba;
    logic [DW-1:0] rad, rbd;
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i] = '0;
      shadow[i]  = '0;
    end
    ram_dout = '0;
    model_reset();

    // Reset with both requesting: grants and outputs held low.
    reset_n = 1'b0;
    a_req = 1'b1; b_req = 1'b1; a_wen = 1'b0; b_wen = 1'b0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
    check_val("rst_b_gnt", {31'd0, b_gnt}, 32'd0);
    check_val("rst_ram_wen", {31'd0, ram_wen}, 32'd0);
    check_val("rst_ram_addr", {20'd0, ram_addr}, 32'd0);
    check_val("rst_ram_din", ram_din, 32'd0);
    check_val("rst_a_rdata", a_rdata, 32'd0);
    check_val("rst_b_rdata", b_rdata, 32'd0);
    check_val("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    reset_n = 1'b1;
    #1;
    check_val("first_gnt_a", {31'd0, a_gnt}, 32'd1);

    // Edge data: unwritten top address reads zero.
    step(1'b1, 1'b0, 12'hFFF, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, g);
    step(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, g);
    check_val("rd_fff", a_rdata, 32'h0000_0000);

    // Single port A write then read.
    step(1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF, 1'b0, 1'b0, 12'h0, 32'h0, g);
    step(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, g);
    step(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, g);
    check_val("a_deadbeef", a_rdata, 32'hDEAD_BEEF);
    check_val("b_quiet", b_rdata, 32'h0);

    // Write followed immediately by read of the same address.
    step(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 12'h123, 32'hCAFE_F00D, g);
    step(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 12'h123, 32'h0, g);
    step(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, g);
    check_val("b_wr_rd", b_rdata, 32'hCAFE_F00D);

    // Mid-flight reset drops the pending read.
    step(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, g);
    pulse_reset();
    step(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, g);
    check_val("midrst_rvalid", {31'd0, a_rvalid}, 32'd0);
    step(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, g);

    // Continuous contention from IDLE_A: A x4, B x4, repeating.
    @(posedge clk); #1;
    pulse_reset();
    ai = 0; bi = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, AW'(12'h100 + ai), 32'h0, 1'b1, 1'b0, AW'(12'h200 + bi), 32'h0, g);
      check_val("burst_pattern", g, (i / 4) % 2);
      if (g == 0) ai++;
      if (g == 1) bi++;
    end

    // Fairness after idle, both directions.
    step(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 12'h5, 32'h0, g);
    step(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, g);
    step(1'b1, 1'b0, 12'h6, 32'h0, 1'b1, 1'b0, 12'h7, 32'h0, g);
    check_val("fair_a_first", g, 0);
    step(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, g);
    step(1'b1, 1'b0, 12'h8, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, g);
    step(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, g);
    step(1'b1, 1'b0, 12'h9, 32'h0, 1'b1, 1'b0, 12'hA, 32'h0, g);
    check_val("fair_b_first", g, 1);
    step(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, g);

    // Lone requester B: ten grants, counter saturates, then A gets in.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b0, AW'(12'h300 + i), 32'h0, g);
      check_val("lone_b", g, 1);
    end
    check_val("cnt_sat", {29'd0, dut.cnt_r}, 32'd4);
    step(1'b1, 1'b0, 12'h400, 32'h0, 1'b1, 1'b0, 12'h30A, 32'h0, g);
    check_val("lone_then_a", g, 0);

    // Randomized traffic; commands are held until granted.
    ra = 1'b0; rb = 1'b0; rw_a = 1'b0; rw_b = 1'b0;
    raa = '0; rba = '0; rad = '0; rbd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!ra && $urandom_range(0, 9) < 7) begin
        ra = 1'b1; rw_a = 1'($urandom_range(0, 1)); rad = $urandom;
        raa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      end
      if (!rb && $urandom_range(0, 9) < 7) begin
        rb = 1'b1; rw_b = 1'($urandom_range(0, 1)); rbd = $urandom;
        rba = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      end
      step(ra, rw_a, raa, rad, rb, rw_b, rba, rbd, g);
      if (g == 0) ra = 1'b0;
      if (g == 1) rb = 1'b0;
      if ($urandom_range(0, 499) == 0) pulse_reset();
    end
    step(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, g);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
